// File: rtl/c5g_housekeeping_pio_poller.sv
// c5g_housekeeping_pio_poller
// Autonomous Avalon-MM read master for the housekeeping interconnect. It
// periodically scans a bank of PIO data registers, keeps a registered
// snapshot of each port, flags per-port changes and raises a maskable irq.
// Optional feature: define POLL_TIMEOUT_EN to bound the wait for
// readdatavalid with a per-read timeout (sets the sticky timeout_err).
`timescale 1ns/1ps

module c5g_housekeeping_pio_poller #(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int BASE_ADDR = 0,
    parameter int STRIDE    = 16,
    parameter int PERIOD    = 1000,
    parameter int TIMEOUT   = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          scan_now,
    input  logic [NUM_PORTS-1:0]          clear,
    input  logic [NUM_PORTS-1:0]          irq_mask,
    output logic [ADDR_W-1:0]             avm_address,
    output logic                          avm_read,
    input  logic                          avm_waitrequest,
    input  logic                          avm_readdatavalid,
    input  logic [31:0]                   avm_readdata,
    output logic [NUM_PORTS*DATA_W-1:0]   snapshot,
    output logic [NUM_PORTS-1:0]          changed,
    output logic                          irq,
    output logic                          busy,
    output logic                          overrun,
    output logic                          timeout_err
);

    localparam int CNT_W = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_UPDATE
    } state_t;

    state_t                        r_state;
    state_t                        w_nextState;
    logic [CNT_W-1:0]              r_cnt;
    logic                          w_tick;
    logic                          w_startReq;
    logic                          r_pending;
    logic [IDX_W-1:0]              r_idx;
    logic                          w_lastPort;
    logic [DATA_W-1:0]             r_data;
    logic [NUM_PORTS*DATA_W-1:0]   r_snapshot;
    logic [NUM_PORTS-1:0]          r_valid;
    logic [NUM_PORTS-1:0]          r_changed;
    logic [NUM_PORTS-1:0]          w_set;
    logic                          r_irq;
    logic                          r_overrun;
    logic                          w_skip;

    // Bits of readdata above the significant width carry nothing for us.
    generate
        if (DATA_W < 32) begin : g_hiBits
            logic [31-DATA_W:0] w_unusedReaddata;
            assign w_unusedReaddata = avm_readdata[31:DATA_W];
        end
    endgenerate

    assign w_tick      = enable && (r_cnt == '0);
    assign w_startReq  = w_tick || scan_now;
    assign w_lastPort  = (r_idx == IDX_W'(NUM_PORTS - 1));
    assign avm_read    = (r_state == ST_REQ);
    assign avm_address = ADDR_W'(BASE_ADDR) + ADDR_W'(r_idx) * ADDR_W'(STRIDE);
    assign busy        = (r_state != ST_IDLE);
    assign snapshot    = r_snapshot;
    assign changed     = r_changed;
    assign irq         = r_irq;
    assign overrun     = r_overrun;

`ifdef POLL_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] r_waitCnt;
    logic            r_skip;
    logic            r_timeoutErr;
    logic            w_timeoutHit;

    assign w_timeoutHit = (r_state == ST_WAIT) && !avm_readdatavalid &&
                          (r_waitCnt == TO_W'(TIMEOUT - 1));
    assign w_skip       = r_skip;
    assign timeout_err  = r_timeoutErr;

    // Count WAIT cycles per read; remember whether the pending UPDATE came
    // from a timeout so it neither compares nor writes the snapshot.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_waitCnt    <= '0;
            r_skip       <= 1'b0;
            r_timeoutErr <= 1'b0;
        end else begin
            if (r_state == ST_WAIT) begin
                r_waitCnt <= r_waitCnt + 1'b1;
                r_skip    <= w_timeoutHit;
            end else begin
                r_waitCnt <= '0;
            end
            if (w_timeoutHit) begin
                r_timeoutErr <= 1'b1;
            end
        end
    end
`else
    logic [31:0] w_unusedTimeout;

    assign w_unusedTimeout = 32'(TIMEOUT);
    assign w_skip          = 1'b0;
    assign timeout_err     = 1'b0;
`endif

    // Free-running scan period counter; it freezes while scanning is disabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= CNT_W'(PERIOD - 1);
        end else if (enable) begin
            if (r_cnt == '0) begin
                r_cnt <= CNT_W'(PERIOD - 1);
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // Scan state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: one read per port, strictly one outstanding at a time.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_startReq || r_pending) begin
                    w_nextState = ST_REQ;
                end
            end
            ST_REQ: begin
                if (!avm_waitrequest) begin
                    w_nextState = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (avm_readdatavalid) begin
                    w_nextState = ST_UPDATE;
`ifdef POLL_TIMEOUT_EN
                end else if (w_timeoutHit) begin
                    w_nextState = ST_UPDATE;
`endif
                end
            end
            ST_UPDATE: begin
                w_nextState = w_lastPort ? ST_IDLE : ST_REQ;
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    // A port changes only when it already holds a valid value that differs.
    always_comb begin
        w_set = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if ((r_state == ST_UPDATE) && !w_skip && (r_idx == IDX_W'(i)) &&
                r_valid[i] && (r_data != r_snapshot[i*DATA_W +: DATA_W])) begin
                w_set[i] = 1'b1;
            end
        end
    end

    // Port index, start bookkeeping, read capture and snapshot writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending  <= 1'b0;
            r_overrun  <= 1'b0;
            r_idx      <= '0;
            r_data     <= '0;
            r_snapshot <= '0;
            r_valid    <= '0;
        end else begin
            if ((r_state != ST_IDLE) && w_startReq) begin
                r_pending <= 1'b1;
                r_overrun <= 1'b1;
            end else if (r_state == ST_IDLE) begin
                r_pending <= 1'b0;
            end
            if (r_state == ST_IDLE) begin
                r_idx <= '0;
            end else if ((r_state == ST_UPDATE) && !w_lastPort) begin
                r_idx <= r_idx + 1'b1;
            end
            if ((r_state == ST_WAIT) && avm_readdatavalid) begin
                r_data <= avm_readdata[DATA_W-1:0];
            end
            if ((r_state == ST_UPDATE) && !w_skip) begin
                for (int i = 0; i < NUM_PORTS; i++) begin
                    if (r_idx == IDX_W'(i)) begin
                        r_snapshot[i*DATA_W +: DATA_W] <= r_data;
                        r_valid[i]                     <= 1'b1;
                    end
                end
            end
        end
    end

    // Sticky change flags (a new change beats a same-cycle clear) and the
    // registered interrupt built from the previous cycle's flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_changed <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_changed <= w_set | (r_changed & ~clear);
            r_irq     <= |(r_changed & irq_mask);
        end
    end

endmodule

// File: tb/tb_c5g_housekeeping_pio_poller.sv
// tb_c5g_housekeeping_pio_poller
// Directed bench for the housekeeping PIO poller. The bench plays the Avalon
// slave from a scan timeline model (per-port wait states and read latency),
// predicts every output each cycle and adds literal checkpoints.
`timescale 1ns/1ps

module tb_c5g_housekeeping_pio_poller;

    localparam int NP   = 4;
    localparam int DW   = 16;
    localparam int AW   = 16;
    localparam int PER  = 20;
    localparam int TMO  = 8;
    localparam int STR  = 16;
    localparam int BASE = 0;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic              scan_now;
    logic [NP-1:0]     clear;
    logic [NP-1:0]     irq_mask;
    logic [AW-1:0]     avm_address;
    logic              avm_read;
    logic              avm_waitrequest;
    logic              avm_readdatavalid;
    logic [31:0]       avm_readdata;
    logic [NP*DW-1:0]  snapshot;
    logic [NP-1:0]     changed;
    logic              irq;
    logic              busy;
    logic              overrun;
    logic              timeout_err;

    c5g_housekeeping_pio_poller #(
        .NUM_PORTS (NP),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .BASE_ADDR (BASE),
        .STRIDE    (STR),
        .PERIOD    (PER),
        .TIMEOUT   (TMO)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .enable            (enable),
        .scan_now          (scan_now),
        .clear             (clear),
        .irq_mask          (irq_mask),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdatavalid (avm_readdatavalid),
        .avm_readdata      (avm_readdata),
        .snapshot          (snapshot),
        .changed           (changed),
        .irq               (irq),
        .busy              (busy),
        .overrun           (overrun),
        .timeout_err       (timeout_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Slave behaviour per port
    logic [DW-1:0] portVal [NP];
    int            ws      [NP];
    int            lat     [NP];
    bit            noResp  [NP];
    bit            strayRdv;

    // Behavioural model state
    bit            mKnown;
    int            mCnt;
    bit            mScan;
    int            mOff;
    bit            mPending;
    logic [DW-1:0] mSnap  [NP];
    bit            mValid [NP];
    logic [NP-1:0] mChanged;
    bit            mIrq;
    bit            mOverrun;
    bit            mTimeout;
    logic [DW-1:0] mCap;

    function automatic int waitLen(input int p);
        return noResp[p] ? TMO : lat[p];
    endfunction

    function automatic int portLen(input int p);
        return ws[p] + waitLen(p) + 2;
    endfunction

    // Map the scan cycle offset to port, offset within port and phase
    // (0 = request, 1 = waiting for data, 2 = update).
    task automatic locate(output int p, output int r, output int ph);
        p = 0;
        r = mOff;
        while (p < NP - 1 && r >= portLen(p)) begin
            r -= portLen(p);
            p++;
        end
        if (r <= ws[p]) ph = 0;
        else if (r <= ws[p] + waitLen(p)) ph = 1;
        else ph = 2;
    endtask

    function automatic logic [NP*DW-1:0] packSnap();
        logic [NP*DW-1:0] v;
        v = '0;
        for (int i = 0; i < NP; i++) v[i*DW +: DW] = mSnap[i];
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
        end
    endtask

    task automatic driveSlave();
        int p, r, ph;
        avm_waitrequest   = 1'b0;
        avm_readdatavalid = 1'b0;
        avm_readdata      = 32'hA5A5_DEAD;
        if (mScan) begin
            locate(p, r, ph);
            if (ph == 0) begin
                avm_waitrequest = (r < ws[p]);
            end else if (ph == 1 && !noResp[p] && r == ws[p] + lat[p]) begin
                avm_readdatavalid = 1'b1;
                avm_readdata      = {16'hA5A5, portVal[p]};
            end else if (ph == 2 && noResp[p]) begin
                avm_readdatavalid = 1'b1;
                avm_readdata      = {16'h5A5A, ~portVal[p]};
            end
        end else if (strayRdv) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = 32'h0000_BEEF;
        end
    endtask

    task automatic checkOutput();
        int p, r, ph;
        logic          expRead;
        logic [AW-1:0] expAddr;
        expRead = 1'b0;
        expAddr = '0;
        if (mScan) begin
            locate(p, r, ph);
            expRead = (ph == 0);
            expAddr = AW'(BASE + p * STR);
        end
        check("avm_read", 64'(avm_read), 64'(expRead));
        if (expRead) check("avm_address", 64'(avm_address), 64'(expAddr));
        check("busy", 64'(busy), 64'(mScan));
        check("snapshot", 64'(snapshot), 64'(packSnap()));
        check("changed", 64'(changed), 64'(mChanged));
        check("irq", 64'(irq), 64'(mIrq));
        check("overrun", 64'(overrun), 64'(mOverrun));
        check("timeout_err", 64'(timeout_err), 64'(mTimeout));
    endtask

    task automatic modelAdvance();
        int p, r, ph;
        bit req, tk, lastUpd;
        logic [NP-1:0] setv;
        if (reset) begin
            mKnown = 1; mCnt = PER - 1; mScan = 0; mOff = 0; mPending = 0;
            for (int i = 0; i < NP; i++) begin mSnap[i] = '0; mValid[i] = 0; end
            mChanged = '0; mIrq = 0; mOverrun = 0; mTimeout = 0; mCap = '0;
            return;
        end
        if (!mKnown) return;
        tk = enable && (mCnt == 0);
        if (enable) mCnt = (mCnt == 0) ? PER - 1 : mCnt - 1;
        req     = tk || scan_now;
        setv    = '0;
        lastUpd = 0;
        if (mScan) begin
            locate(p, r, ph);
            if (ph == 1 && !noResp[p] && r == ws[p] + lat[p]) mCap = portVal[p];
            if (ph == 1 && noResp[p] && r == ws[p] + TMO) mTimeout = 1;
            if (ph == 2) begin
                if (!noResp[p]) begin
                    if (mValid[p] && mCap != mSnap[p]) setv[p] = 1'b1;
                    mSnap[p]  = mCap;
                    mValid[p] = 1;
                end
                lastUpd = (p == NP - 1);
            end
            if (req) begin mOverrun = 1; mPending = 1; end
        end
        mIrq     = |(mChanged & irq_mask);
        mChanged = setv | (mChanged & ~clear);
        if (mScan) begin
            if (lastUpd) mScan = 0;
            else mOff++;
        end else if (req || mPending) begin
            mScan = 1; mOff = 0; mPending = 0;
        end
    endtask

    // One clock: drive the slave, compare at the falling edge, advance the model.
    task automatic applyStimulus();
        driveSlave();
        @(negedge clk);
        if (mKnown) checkOutput();
        modelAdvance();
        @(posedge clk);
        #1;
        cyc++;
        scan_now = 1'b0;
        clear    = '0;
        strayRdv = 1'b0;
    endtask

    task automatic runUntil(input int n);
        while (cyc < n) applyStimulus();
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; scan_now = 1'b0; clear = '0; irq_mask = '0;
        strayRdv = 1'b0; mKnown = 0;
        avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;
        portVal[0] = 16'h1111; portVal[1] = 16'h2222;
        portVal[2] = 16'h3333; portVal[3] = 16'h4444;
        for (int i = 0; i < NP; i++) begin ws[i] = 0; lat[i] = 1; noResp[i] = 0; end

        applyStimulus();
        applyStimulus();
        check("pin_reset_snapshot", 64'(snapshot), 64'h0);
        check("pin_reset_flags", 64'({changed, irq, busy, overrun, timeout_err, avm_read}), 64'h0);
        reset = 1'b0; enable = 1'b1; cyc = 0;

        // First periodic scan
        runUntil(19);
        check("pin_no_read_before_tick", 64'(avm_read), 64'h0);
        runUntil(20);
        check("pin_first_read", 64'(avm_read), 64'h1);
        check("pin_first_addr", 64'(avm_address), 64'h0);
        runUntil(33);
        check("pin_first_snapshot", 64'(snapshot), 64'h4444_3333_2222_1111);
        check("pin_first_changed", 64'(changed), 64'h0);

        // Port 2 change raises the masked irq; clear drops it
        portVal[2] = 16'h3334; irq_mask = 4'b0100;
        runUntil(52);
        check("pin_changed_port2", 64'(changed), 64'h4);
        check("pin_irq_port2", 64'(irq), 64'h1);
        clear = 4'b0100;
        applyStimulus();
        check("pin_cleared", 64'(changed), 64'h0);
        applyStimulus();
        check("pin_irq_dropped", 64'(irq), 64'h0);

        // Clear collides with detection on port 1
        portVal[1] = 16'h2223;
        runUntil(65);
        clear = 4'b0010;
        applyStimulus();
        check("pin_set_beats_clear", 64'(changed), 64'h2);

        // Five wait states on port 0
        runUntil(72);
        ws[0] = 5;
        runUntil(84);
        check("pin_held_read", 64'({avm_read, avm_address}), 64'h1_0000);
        runUntil(96);
        check("pin_busy_end", 64'(busy), 64'h1);
        runUntil(97);
        check("pin_idle_after_17", 64'(busy), 64'h0);

        // Overrun from scan_now during a scan, with varied slave timing
        ws[0] = 0; ws[2] = 2; lat[3] = 3;
        runUntil(105);
        scan_now = 1'b1;
        applyStimulus();
        check("pin_overrun", 64'(overrun), 64'h1);
        enable = 1'b0;
        runUntil(110);
        scan_now = 1'b1;
        runUntil(116);
        check("pin_gap", 64'(busy), 64'h0);
        runUntil(117);
        check("pin_rescan", 64'(busy), 64'h1);
        runUntil(134);
        check("pin_single_rescan", 64'(busy), 64'h0);
        runUntil(135);
        strayRdv = 1'b1;
        runUntil(140);
        enable = 1'b1;
        runUntil(153);
        check("pin_counter_held", 64'(avm_read), 64'h0);
        runUntil(154);
        check("pin_counter_resumed", 64'(avm_read), 64'h1);

        // Port 3 read without (or with) response
        runUntil(170);
        enable = 1'b0;
        runUntil(171);
        portVal[3] = 16'h4445;
`ifdef POLL_TIMEOUT_EN
        noResp[3] = 1;
`endif
        runUntil(172);
        scan_now = 1'b1;
`ifdef POLL_TIMEOUT_EN
        runUntil(192);
        check("pin_no_timeout_yet", 64'(timeout_err), 64'h0);
        runUntil(193);
        check("pin_timeout", 64'(timeout_err), 64'h1);
        runUntil(194);
        check("pin_timeout_idle", 64'(busy), 64'h0);
        runUntil(195);
        check("pin_timeout_snapshot", 64'(snapshot[63:48]), 64'h4444);
        noResp[3] = 0;
`else
        runUntil(190);
        check("pin_port3_snapshot", 64'(snapshot[63:48]), 64'h4445);
        check("pin_timeout_tied", 64'(timeout_err), 64'h0);
        check("pin_port3_idle", 64'(busy), 64'h0);
`endif

        // Reset in the middle of a scan, then a clean scan afterwards
        runUntil(200);
        scan_now = 1'b1;
        runUntil(205);
        reset = 1'b1;
        applyStimulus();
        check("pin_midreset_read", 64'(avm_read), 64'h0);
        check("pin_midreset_outputs", 64'({snapshot, changed, irq, busy, overrun, timeout_err}), 64'h0);
        reset = 1'b0;
        portVal[0] = 16'h9999;
        runUntil(210);
        scan_now = 1'b1;
        runUntil(228);
        check("pin_post_reset_snapshot", 64'(snapshot), 64'h4445_3334_2223_9999);
        check("pin_post_reset_changed", 64'(changed), 64'h0);
        runUntil(232);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/c5g_housekeeping_pio_poller.md
# c5g_housekeeping_pio_poller

Autonomous Avalon-MM master that periodically scans a bank of housekeeping PIO input ports (hardware-info, switches, status words) and keeps a registered snapshot of each. It flags per-port changes and raises a maskable interrupt, so the Nios firmware does not have to busy-poll the PIOs. It sits on the housekeeping interconnect beside the CPU data master and shares the PIO slaves with it.

## Interface
- NUM_PORTS, 4, number of PIO slaves scanned (1..8)
- ADDR_W, 16, master address width
- DATA_W, 16, significant low bits of each PIO readdata
- BASE_ADDR, 0, byte address of port 0 data register
- STRIDE, 16, byte spacing between ports (one 4-register PIO span)
- PERIOD, 1000, clk cycles between scan starts (>= 2)
- TIMEOUT, 64, max cycles waiting for readdatavalid (with POLL_TIMEOUT_EN)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  periodic scanning enabled
- scan_now  in  1  one-cycle pulse: request an immediate scan
- clear  in  NUM_PORTS  one-cycle pulses: clear changed[i]
- irq_mask  in  NUM_PORTS  per-port interrupt enable
- avm_address  out  ADDR_W  read address
- avm_read  out  1  read request
- avm_waitrequest  in  1  interconnect stall
- avm_readdatavalid  in  1  read data valid
- avm_readdata  in  32  read data; bits above DATA_W ignored
- snapshot  out  NUM_PORTS*DATA_W  last value per port, port i at [i*DATA_W +: DATA_W]
- changed  out  NUM_PORTS  sticky per-port change flags
- irq  out  1  registered OR of changed & irq_mask
- busy  out  1  scan in progress
- overrun  out  1  sticky: start request arrived while busy
- timeout_err  out  1  sticky: a read timed out

## Operation
- Reset: all outputs 0, snapshot 0, period counter loaded with PERIOD-1, state IDLE, all port valid bits 0.
- Period counter decrements every cycle while enable=1. At 0 it reloads PERIOD-1 and issues a tick. It holds its value while enable=0.
- Start request = tick OR scan_now. If a start request arrives in IDLE, the scan starts. Otherwise overrun is set and a single pending start is recorded. Further requests while a start is pending are merged into it.
- FSM states:
  - IDLE: on a start request or a pending start, go to REQ with idx=0 and clear pending.
  - REQ: avm_read=1, avm_address=BASE_ADDR+idx*STRIDE. Hold both until avm_waitrequest=0, then go to WAIT.
  - WAIT: on avm_readdatavalid, capture readdata[DATA_W-1:0] and go to UPDATE.
  - UPDATE: if valid[idx]=1 and the captured value differs from snapshot[idx], set changed[idx]. Write the snapshot, set valid[idx], then idx+1. After the last port, return to IDLE; otherwise return to REQ.
- The first read of each port after reset never sets changed.
- If clear[i] and a set of changed[i] occur in the same cycle, set wins.
- busy=1 in every state except IDLE.
- irq is registered one cycle after changed/irq_mask. It stays asserted until the masked flags are all 0.
- Reset asserted mid-scan: return to IDLE on the next edge, with avm_read=0 in the following cycle. Any read still outstanding is discarded: readdatavalid is ignored in IDLE.

## Timing
- A start request in cycle T gives avm_read=1 in T+1.
- Per port with zero wait states and read latency 1: 3 cycles (REQ, WAIT, UPDATE).
- changed and snapshot update in the cycle after UPDATE, and irq one cycle later.
- Full scan: 3*NUM_PORTS cycles plus 1 IDLE cycle. The design requires PERIOD > 3*NUM_PORTS+1 for overrun-free operation.
- At most one read outstanding. avm_address is stable while avm_read=1.

## Configuration
- POLL_TIMEOUT_EN defined:
  - A WAIT-state counter runs for each read.
  - If it reaches TIMEOUT with no readdatavalid, timeout_err is set, the snapshot is left unchanged, and the FSM goes to UPDATE with a no-write, no-compare action.
  - Any late readdatavalid is ignored until the next WAIT.
- POLL_TIMEOUT_EN undefined: WAIT waits indefinitely and timeout_err is tied to 0.

## Test plan
- Reset, enable=1, PERIOD=20, 4 ports returning 0x1111/0x2222/0x3333/0x4444 -> first avm_read at cycle 20. Addresses are 0x0, 0x10, 0x20, 0x30. snapshot matches, changed=0, irq=0.
- Port 2 changes to 0x3334 before the second scan, irq_mask=4'b0100 -> changed=4'b0100 and irq=1. Pulse clear[2] -> changed=0 and irq=0 two cycles later.
- clear[1] pulsed in the same cycle port 1's change is detected -> changed[1]=1.
- avm_waitrequest held 5 cycles on port 0 -> avm_read and avm_address are held stable. The scan completes in 12+5+1 cycles.
- PERIOD=10 with NUM_PORTS=4 -> overrun=1 and exactly one back-to-back rescan; busy never gaps more than 1 cycle.
- POLL_TIMEOUT_EN with TIMEOUT=8 and readdatavalid suppressed on port 3 -> timeout_err=1 after 8 WAIT cycles. snapshot[3] is unchanged and the FSM reaches IDLE. Reset mid-scan -> avm_read=0 and all outputs 0.
